// File: rtl/spw_rx_pkt_buffer.sv
// SpaceWire RX packet buffer: drains SPW_TOP's RX FIFO into a show-ahead buffer and counts whole packets.
// Optional SPW_RX_DROP_EEP_EN: EEP-terminated packets are discarded and OVERFLOW reports dropped oversize packets.
module spw_rx_pkt_buffer #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic [8:0]            DATA_O,
    input  logic                  RX_EMPTY,
    output logic                  RD_DATA,
    output logic [8:0]            HOST_DATA,
    output logic                  HOST_VALID,
    input  logic                  HOST_POP,
    output logic [DEPTH_LOG2:0]   LEVEL,
    output logic [DEPTH_LOG2:0]   PKT_COUNT,
    output logic                  PKT_AVAIL,
    output logic                  EEP_FLAG,
`ifdef SPW_RX_DROP_EEP_EN
    output logic                  OVERFLOW,
`endif
    input  logic                  CLR_FLAGS
);

    localparam int PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] FULL = PW'(1) << DEPTH_LOG2;
    localparam logic [8:0] EEP_CHAR = 9'h101;

    typedef enum logic [1:0] {IDLE, REQ, CAPT} state_t;

    state_t        state_q;
    logic          rd_data_q;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] pkt_q, pkt_d;
    logic          eep_q, eep_d;
    logic [8:0]    mem_q [2**DEPTH_LOG2];

    logic [PW-1:0] level;
    logic [8:0]    head;
    logic          host_valid;
    logic          pop;
    logic          we;
    logic          inc;
    logic          set_eep;
    logic          fetch_ok;
    logic          is_eep;
    logic          is_ctl;

`ifdef SPW_RX_DROP_EEP_EN
    logic [PW-1:0] wr_cmt_q, wr_cmt_d;
    logic          discard_q, discard_d;
    logic          ovf_q, ovf_d;
    logic          start_discard;
`endif

    assign level  = wr_ptr_q - rd_ptr_q;
    assign head   = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign is_eep = (DATA_O == EEP_CHAR);
    assign is_ctl = DATA_O[8];

`ifdef SPW_RX_DROP_EEP_EN
    assign host_valid = (rd_ptr_q != wr_cmt_q);
    // Full with nothing committed ahead of the writer: the host can never drain it, so drop the packet.
    assign start_discard = (state_q == IDLE) && (level == FULL) &&
                           (wr_cmt_q == rd_ptr_q) && !discard_q;
    assign fetch_ok = !RX_EMPTY && ((level != FULL) || discard_q);
    assign OVERFLOW = ovf_q;
`else
    assign host_valid = (level != '0);
    assign fetch_ok   = !RX_EMPTY && (level != FULL);
`endif

    assign pop        = HOST_POP && host_valid;
    assign HOST_VALID = host_valid;
    assign HOST_DATA  = host_valid ? head : 9'h000;
    assign LEVEL      = level;
    assign PKT_COUNT  = pkt_q;
    assign PKT_AVAIL  = (pkt_q != '0);
    assign EEP_FLAG   = eep_q;
    assign RD_DATA    = rd_data_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        we       = 1'b0;
        inc      = 1'b0;
        set_eep  = 1'b0;
`ifdef SPW_RX_DROP_EEP_EN
        wr_cmt_d  = wr_cmt_q;
        discard_d = discard_q;
        ovf_d     = ovf_q;
        if (start_discard) begin
            discard_d = 1'b1;
            ovf_d     = 1'b1;
        end else if (CLR_FLAGS) begin
            ovf_d = 1'b0;
        end
        if (state_q == CAPT) begin
            if (discard_q) begin
                if (is_ctl) begin
                    wr_ptr_d  = wr_cmt_q;
                    discard_d = 1'b0;
                    set_eep   = is_eep;
                end
            end else if (is_eep) begin
                wr_ptr_d = wr_cmt_q;
                set_eep  = 1'b1;
            end else begin
                we       = 1'b1;
                wr_ptr_d = wr_ptr_q + PW'(1);
                if (is_ctl) begin
                    wr_cmt_d = wr_ptr_q + PW'(1);
                    inc      = 1'b1;
                end
            end
        end
`else
        if (state_q == CAPT) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            inc      = is_ctl;
            set_eep  = is_eep;
        end
`endif
        rd_ptr_d = rd_ptr_q + PW'(pop);
        pkt_d    = pkt_q + PW'(inc) - PW'(pop && head[8]);
        eep_d    = set_eep ? 1'b1 : (CLR_FLAGS ? 1'b0 : eep_q);
    end

    always_ff @(posedge CLOCK) begin
        if (we) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= DATA_O;
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            rd_data_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pkt_q     <= '0;
            eep_q     <= 1'b0;
`ifdef SPW_RX_DROP_EEP_EN
            wr_cmt_q  <= '0;
            discard_q <= 1'b0;
            ovf_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (fetch_ok) begin
                        state_q   <= REQ;
                        rd_data_q <= 1'b1;
                    end
                end
                REQ: begin
                    state_q   <= CAPT;
                    rd_data_q <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    rd_data_q <= 1'b0;
                end
            endcase
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            pkt_q    <= pkt_d;
            eep_q    <= eep_d;
`ifdef SPW_RX_DROP_EEP_EN
            wr_cmt_q  <= wr_cmt_d;
            discard_q <= discard_d;
            ovf_q     <= ovf_d;
`endif
        end
    end

endmodule
